// File: rtl/circ_smpl_queue.sv
// Multi-channel circular sample queue for the audio FIR path.
// Keeps the newest DEPTH samples and streams a WINDOW burst per write once full.
module circ_smpl_queue #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 1536,
  parameter int WINDOW   = 1021,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] new_smpl,
  input  logic                      wrt_smpl,
  input  logic                      flush,
  input  logic                      clr_ovr,
  output logic [CHANNELS*WIDTH-1:0] smpl_out,
  output logic                      smpl_vld,
  output logic                      first,
  output logic                      last,
  output logic                      sequencing,
  output logic                      full,
  output logic                      overrun,
  output logic [AW:0]               fill_cnt
);

  localparam int DW  = CHANNELS*WIDTH;
  localparam int AW1 = AW+1;

  localparam logic [AW-1:0] PTR_MAX   = AW'(DEPTH-1);
  localparam logic [AW:0]   FILL_MAX  = AW1'(DEPTH);
  localparam logic [AW:0]   WIN_W     = AW1'(WINDOW);
  localparam logic [AW-1:0] WIN_A     = AW'(WINDOW);
  localparam logic [AW-1:0] WRAP_OFS  = AW'(DEPTH-WINDOW);
  localparam logic [AW-1:0] BCNT_INIT = AW'(WINDOW-1);

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] bcnt;
  logic          rd_act;

  logic          accept;
  logic          drop;
  logic          trig;
  logic [AW-1:0] wr_nxt;
  logic [AW-1:0] rd_nxt;
  logic [AW-1:0] start;
  logic [AW:0]   fill_nxt;

  // rd_act covers address issue, smpl_vld the trailing data cycle
  assign sequencing = rd_act | smpl_vld;

  always_comb begin
    accept   = wrt_smpl & ~sequencing & ~flush;
    drop     = wrt_smpl & sequencing & ~flush;
    wr_nxt   = (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
    rd_nxt   = (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
    fill_nxt = (fill_cnt == FILL_MAX) ? FILL_MAX
                                      : fill_cnt + 1'b1;
    trig     = accept & (fill_nxt == FILL_MAX);
    // modulo-DEPTH subtract without power-of-two wrap
    start    = ({1'b0, wr_nxt} >= WIN_W) ? wr_nxt - WIN_A
                                         : wr_nxt + WRAP_OFS;
  end

  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_ptr] <= new_smpl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      bcnt     <= '0;
      rd_act   <= 1'b0;
      fill_cnt <= '0;
      full     <= 1'b0;
      smpl_vld <= 1'b0;
      first    <= 1'b0;
      last     <= 1'b0;
      smpl_out <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      full     <= 1'b0;
      rd_act   <= 1'b0;
      smpl_vld <= 1'b0;
      first    <= 1'b0;
      last     <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr   <= wr_nxt;
        fill_cnt <= fill_nxt;
        full     <= (fill_nxt == FILL_MAX);
      end
      unique case (1'b1)
        trig: begin
          rd_act <= 1'b1;
          rd_ptr <= start;
          bcnt   <= BCNT_INIT;
        end
        rd_act: begin
          rd_ptr <= rd_nxt;
          bcnt   <= bcnt - 1'b1;
          if (bcnt == '0)
            rd_act <= 1'b0;
        end
        default: ;
      endcase
      smpl_vld <= rd_act;
      first    <= rd_act & (bcnt == BCNT_INIT);
      last     <= rd_act & (bcnt == '0);
      if (rd_act)
        smpl_out <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overrun <= 1'b0;
    else if (drop)
      overrun <= 1'b1;
    else if (clr_ovr)
      overrun <= 1'b0;
  end

endmodule

// File: tb/tb_circ_smpl_queue.sv
// Directed bench for circ_smpl_queue: three builds (8/4, 6/4, 4/4)
// sharing stimulus, one selected at a time.
module tb_circ_smpl_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] din = '0;
  logic        wrt = 1'b0;
  logic        flush = 1'b0;
  logic        clr = 1'b0;
  int          sel = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  logic [31:0] so_a, so_b, so_c;
  logic        vld_a, vld_b, vld_c;
  logic        fst_a, fst_b, fst_c;
  logic        lst_a, lst_b, lst_c;
  logic        seq_a, seq_b, seq_c;
  logic        ful_a, ful_b, ful_c;
  logic        ovr_a, ovr_b, ovr_c;
  logic [3:0]  fc_a, fc_b;
  logic [2:0]  fc_c;

  circ_smpl_queue #(.WIDTH(16), .CHANNELS(2), .DEPTH(8), .WINDOW(4)) u_a (
    .clk(clk), .rst_n(rst_n), .new_smpl(din),
    .wrt_smpl(wrt & (sel == 0)), .flush(flush & (sel == 0)),
    .clr_ovr(clr & (sel == 0)),
    .smpl_out(so_a), .smpl_vld(vld_a), .first(fst_a), .last(lst_a),
    .sequencing(seq_a), .full(ful_a), .overrun(ovr_a), .fill_cnt(fc_a)
  );

  circ_smpl_queue #(.WIDTH(16), .CHANNELS(2), .DEPTH(6), .WINDOW(4)) u_b (
    .clk(clk), .rst_n(rst_n), .new_smpl(din),
    .wrt_smpl(wrt & (sel == 1)), .flush(flush & (sel == 1)),
    .clr_ovr(clr & (sel == 1)),
    .smpl_out(so_b), .smpl_vld(vld_b), .first(fst_b), .last(lst_b),
    .sequencing(seq_b), .full(ful_b), .overrun(ovr_b), .fill_cnt(fc_b)
  );

  circ_smpl_queue #(.WIDTH(16), .CHANNELS(2), .DEPTH(4), .WINDOW(4)) u_c (
    .clk(clk), .rst_n(rst_n), .new_smpl(din),
    .wrt_smpl(wrt & (sel == 2)), .flush(flush & (sel == 2)),
    .clr_ovr(clr & (sel == 2)),
    .smpl_out(so_c), .smpl_vld(vld_c), .first(fst_c), .last(lst_c),
    .sequencing(seq_c), .full(ful_c), .overrun(ovr_c), .fill_cnt(fc_c)
  );

  logic [31:0] so;
  logic        vld, fst, lst, seq, ful, ovr;
  logic [3:0]  fc;

  always_comb begin
    so = so_a; vld = vld_a; fst = fst_a; lst = lst_a;
    seq = seq_a; ful = ful_a; ovr = ovr_a; fc = fc_a;
    if (sel == 1) begin
      so = so_b; vld = vld_b; fst = fst_b; lst = lst_b;
      seq = seq_b; ful = ful_b; ovr = ovr_b; fc = fc_b;
    end else if (sel == 2) begin
      so = so_c; vld = vld_c; fst = fst_c; lst = lst_c;
      seq = seq_c; ful = ful_c; ovr = ovr_c; fc = {1'b0, fc_c};
    end
  end

  function automatic logic [31:0] smp(input logic [15:0] v);
    return {v ^ 16'hFFFF, v};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out"}, so, 32'h0);
    chk({tag, "_flags"}, {vld, fst, lst, seq, ful, ovr}, 6'b0);
    chk({tag, "_fill"}, fc, 4'd0);
  endtask

  task automatic wr_run(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wrt = 1'b1;
      din = smp(16'(base + i));
    end
    @(negedge clk);
    wrt = 1'b0;
  endtask

  // ev: 0 none, 1 drop+clr_ovr, 2 flush+write, 3 async reset
  task automatic burst(input int v, input int v0, input int ek,
                       input int ev, input string tag);
    @(negedge clk);
    wrt = 1'b1;
    din = smp(16'(v));
    @(negedge clk);
    wrt = 1'b0;
    chk({tag, "_t1"}, {ful, seq, vld}, 3'b110);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      wrt = 1'b0;
      clr = 1'b0;
      if (ev == 2 && k == ek + 1) begin
        chk({tag, "_flushed"}, {vld, fst, lst, seq, ful, ovr}, 6'b0);
        chk({tag, "_fill0"}, fc, 4'd0);
        flush = 1'b0;
        return;
      end
      if (ev == 1 && k == ek + 1) begin
        chk({tag, "_ovr"}, ovr, 1'b1);
        chk({tag, "_fill"}, fc, 4'd8);
      end
      chk({tag, "_data"}, so, smp(16'(v0 + k)));
      chk({tag, "_vfl"}, {vld, fst, lst, seq},
          {1'b1, k == 0, k == 3, 1'b1});
      if (k == ek) begin
        if (ev == 1) begin
          wrt = 1'b1; clr = 1'b1; din = smp(16'h0055);
        end
        if (ev == 2) begin
          flush = 1'b1; wrt = 1'b1; din = smp(16'h0066);
        end
        if (ev == 3) begin
          #2 rst_n = 1'b0;
          #1 check_zero({tag, "_async"});
          return;
        end
      end
    end
    @(negedge clk);
    chk({tag, "_end"}, {seq, vld}, 2'b00);
    chk({tag, "_hold"}, so, smp(16'(v0 + 3)));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_zero("reset_a");
    sel = 2;
    #1 check_zero("reset_c");
    sel = 0;
    rst_n = 1'b1;

    wr_run(7, 1);
    chk("fill7", fc, 4'd7);
    chk("fill7_flags", {ful, seq, vld}, 3'b000);

    burst(8, 5, -1, 0, "b8");
    burst(9, 6, -1, 0, "wrap8");

    burst(10, 7, 1, 1, "drop");
    chk("ovr_hold", ovr, 1'b1);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("ovr_clr", ovr, 1'b0);
    burst(11, 8, -1, 0, "post_drop");
    chk("post_drop_fill", fc, 4'd8);

    burst(12, 9, 1, 2, "flush");
    wr_run(7, 21);
    chk("refill7", fc, 4'd7);
    chk("refill7_flags", {ful, seq, vld, ovr}, 4'b0000);
    burst(28, 25, -1, 0, "refill");

    sel = 1;
    wr_run(5, 1);
    chk("d6_fill5", fc, 4'd5);
    burst(6, 3, -1, 0, "d6_first");
    burst(7, 4, -1, 0, "d6_wrap");

    sel = 0;
    burst(29, 26, 1, 3, "rst");
    @(negedge clk);
    check_zero("rst_held");
    rst_n = 1'b1;

    sel = 2;
    wr_run(3, 1);
    chk("d4_fill3", fc, 4'd3);
    burst(4, 1, -1, 0, "d4");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
